// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory arbiter: FSM state encoding, the
//   arbitration policy selectors and the channel-id width helper.
//   No ports; imported by arb_pick and mem_arbiter_n.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_n_arb_pick.sv
// arb_pick
//   Combinational winner select for the memory arbiter.
//   Fixed mode: lowest-index requester wins.
//   Round-robin mode: first requester at or after ptr wins, wrapping at NUM_CH.
// Ports
//   req     in   NUM_CH   request vector
//   ptr     in   ID_W     round-robin start channel
//   rr_mode in   1        1 = round robin, 0 = fixed priority
//   id      out  ID_W     winning channel (0 when none)
//   valid   out  1        at least one request present
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              rr_mode,
  output logic [ID_W-1:0]   id,
  output logic              valid
);

  // Scan candidates in priority order; the first hit is the winner.
  always_comb begin
    int               sum;
    logic [ID_W-1:0]  cand;
    id    = '0;
    valid = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = rr_mode ? (int'(ptr) + i) : i;
      if (sum >= NUM_CH) begin
        sum = sum - NUM_CH;
      end
      cand = ID_W'(sum);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        id    = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n
//   Grants one single-port memory to NUM_CH requesters, one access in flight.
//   Fixed-priority (MODE=0) or round-robin (MODE=1). Each access ends with a
//   one-cycle done pulse for its channel; read results are held per channel.
// Ports
//   clock      in   1               rising-edge clock
//   reset      in   1               asynchronous, active-low reset
//   module_en  in   1               1 = new grants allowed
//   req_en     in   NUM_CH          per-channel request, held until done
//   req_we     in   NUM_CH          per-channel write (1) / read (0)
//   req_addr   in   NUM_CH*ADDR_W   flat request addresses
//   req_wdata  in   NUM_CH*DATA_W   flat write data
//   rd_data    out  NUM_CH*DATA_W   flat held read results
//   done       out  NUM_CH          completion pulse
//   busy       out  1               access in flight
//   grant_id   out  3               channel being served
//   mem_en     out  1               memory enable pulse
//   mem_we     out  1               memory write enable
//   mem_addr   out  ADDR_W          memory address
//   mem_wdata  out  DATA_W          memory write data
//   mem_rdata  in   DATA_W          memory read data
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int MODE    = 0,
  parameter int MEM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     module_en,
  input  logic [NUM_CH-1:0]        req_en,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0]        done,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int              ID_W     = id_width(NUM_CH);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_CH - 1);
  localparam logic [2:0]      LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic            RR_MODE  = 1'(MODE == MODE_RR);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic              grant;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [2:0]        lat_cnt;

  arb_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req     (req_en),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE),
    .id      (pick_id),
    .valid   (pick_valid)
  );

  assign grant = (state == ST_IDLE) && module_en && pick_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = cur_we ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (lat_cnt == LAT_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured at grant so that the requester may change or
  // drop them mid-access without disturbing the memory port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_id    <= '0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      lat_cnt   <= '0;
      rr_ptr    <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            cur_id    <= pick_id;
            cur_we    <= req_we[pick_id];
            cur_addr  <= req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
            cur_wdata <= req_wdata[int'(pick_id)*DATA_W +: DATA_W];
          end
        end
        ST_ISSUE: begin
          lat_cnt <= '0;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rd_data[int'(cur_id)*DATA_W +: DATA_W] <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          // The served channel moves to the back of the rotation.
          rr_ptr <= (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);
        end
        default: begin
          lat_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    done      = '0;
    busy      = 1'b0;
    grant_id  = 3'd0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_ISSUE: begin
        busy      = 1'b1;
        grant_id  = 3'(cur_id);
        mem_en    = 1'b1;
        mem_we    = cur_we;
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        grant_id = 3'(cur_id);
      end
      ST_DONE: begin
        done[cur_id] = 1'b1;
        grant_id     = 3'(cur_id);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
